fpnew_sdotp_arbiter: RTL

FPNEW_SDOTP_ARBITER -- requirements
Module: fpnew_sdotp_arbiter

---
 rtl/fpnew_pkg.sv | 36 +++
 rtl/fpnew_sdotp_id_fifo.sv | 81 ++++++++
 rtl/fpnew_sdotp_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// ---------------------------------------------------------------------------
// fpnew_pkg
// Shared types for the sdotp arbiter slice.
//   - sdotp_req_t / sdotp_rsp_t : packed request and response payloads
//   - id_width()                : bits needed to name one of n requesters
// ---------------------------------------------------------------------------
package fpnew_pkg;

    localparam int unsigned SdotpReqDataWidth = 3*64 + 16;
    localparam int unsigned SdotpRspDataWidth = 64 + 6;

    // Request payload: three operands, then operation, modifier, formats and
    // rounding mode. The 16 control bits are packed below the operands.
    typedef struct packed {
        logic [2:0][63:0] operands;
        logic [3:0]       op;
        logic             op_mod;
        logic [2:0]       src_fmt;
        logic [2:0]       dst_fmt;
        logic [1:0]       int_fmt;
        logic [2:0]       rnd_mode;
    } sdotp_req_t;

    // Response payload: result, IEEE status flags and the extension bit.
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  status;
        logic        ext_bit;
    } sdotp_rsp_t;

    // A single requester still needs one bit so that vectors stay legal.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_sdotp_id_fifo.sv
// ---------------------------------------------------------------------------
// fpnew_sdotp_id_fifo
// In-order FIFO of requester IDs, one entry per operation in flight.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : empties the FIFO on the next edge (wins over push/pop)
//   push_i/id_i   : store id_i unless full (no pass-through when full)
//   pop_i         : drop the head unless empty
//   full_o/empty_o: occupancy flags
//   head_o        : ID at the head
// ---------------------------------------------------------------------------
module fpnew_sdotp_id_fifo #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [IdWidth-1:0] id_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [IdWidth-1:0] head_o
);

    localparam int unsigned AddrWidth = $clog2(Depth);
    localparam int unsigned PtrWidth  = AddrWidth + 1;

    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [IdWidth-1:0]  mem_q [Depth];
    logic                push_ok;
    logic                pop_ok;

    // The extra pointer MSB tells a full FIFO (wrapped once) from an empty one.
    assign full_o  = (wptr_q[PtrWidth-1] != rptr_q[PtrWidth-1]) &&
                     (wptr_q[AddrWidth-1:0] == rptr_q[AddrWidth-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AddrWidth-1:0]];

    // Full is checked before any pop, so a full FIFO never accepts a push
    // even when its head leaves in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer values; a flush rewinds both pointers to the origin.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PtrWidth'(1);
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PtrWidth'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wptr_q[AddrWidth-1:0]] <= id_i;
        end
    end

endmodule

// File: rtl/fpnew_sdotp_arbiter.sv
// ---------------------------------------------------------------------------
// fpnew_sdotp_arbiter
// Shares one dot-product unit between NumReq requesters. Requests are granted
// round-robin; the granted index is queued so that in-order results go back
// to the requester that issued them.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   flush_i                : drop every in-flight ID, forwarded to the unit
//   req_valid_i/ready_o    : per-requester request handshake
//   req_data_i             : per-requester payload
//   rsp_valid_o/ready_i    : per-requester response handshake
//   rsp_data_o             : shared response payload (unit result, no delay)
//   unit_req_*             : issue handshake towards the unit
//   unit_rsp_*             : result handshake from the unit
//   unit_flush_o           : flush_i passed through
//   busy_o                 : something is in flight
//   err_o                  : sticky, a result came with nothing in flight
// ---------------------------------------------------------------------------
module fpnew_sdotp_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned ReqDataWidth   = 3*64 + 16,
    parameter int unsigned RspDataWidth   = 64 + 6,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    input  logic [NumReq-1:0][ReqDataWidth-1:0]  req_data_i,
    output logic [NumReq-1:0]                    rsp_valid_o,
    input  logic [NumReq-1:0]                    rsp_ready_i,
    output logic [RspDataWidth-1:0]              rsp_data_o,
    output logic                                 unit_req_valid_o,
    input  logic                                 unit_req_ready_i,
    output logic [ReqDataWidth-1:0]              unit_req_data_o,
    input  logic                                 unit_rsp_valid_i,
    output logic                                 unit_rsp_ready_o,
    input  logic [RspDataWidth-1:0]              unit_rsp_data_i,
    output logic                                 unit_flush_o,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int unsigned IdWidth   = id_width(NumReq);
    localparam int unsigned CandWidth = IdWidth + 1;

    logic [IdWidth-1:0]   rr_q, rr_d;
    logic                 err_q, err_d;
    logic [IdWidth-1:0]   gnt_idx;
    logic                 gnt_found;
    logic [CandWidth-1:0] cand;
    logic                 issue;
    logic                 rsp_pop;
    logic                 id_full;
    logic                 id_empty;
    logic [IdWidth-1:0]   head;

    // Round-robin search: the first valid requester at or after rr_q,
    // wrapping past NumReq-1 back to 0.
    always_comb begin
        gnt_idx   = rr_q;
        gnt_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, rr_q} + CandWidth'(i);
            if (cand >= CandWidth'(NumReq)) begin
                cand = cand - CandWidth'(NumReq);
            end
            if (!gnt_found && req_valid_i[cand[IdWidth-1:0]]) begin
                gnt_idx   = cand[IdWidth-1:0];
                gnt_found = 1'b1;
            end
        end
    end

    assign unit_req_valid_o = gnt_found && !id_full && !flush_i;
    assign unit_req_data_o  = req_data_i[gnt_idx];
    assign issue            = unit_req_valid_o && unit_req_ready_i;
    assign unit_flush_o     = flush_i;

    // Only the granted requester sees ready, and only when the unit takes it.
    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = issue;
    end

    // Results come back in issue order, so the FIFO head names their owner.
    // With nothing in flight the unit is drained unconditionally.
    assign unit_rsp_ready_o = id_empty ? 1'b1 : rsp_ready_i[head];
    assign rsp_pop          = unit_rsp_valid_i && unit_rsp_ready_o && !id_empty;
    assign rsp_data_o       = unit_rsp_data_i;
    assign busy_o           = !id_empty && rst_ni;
    assign err_o            = err_q;

    // Reset is synchronous, so the FIFO may still look occupied during the
    // first reset cycle; gating with rst_ni keeps responses quiet meanwhile.
    always_comb begin
        rsp_valid_o = '0;
        if (!id_empty && rst_ni) begin
            rsp_valid_o[head] = unit_rsp_valid_i;
        end
    end

    // The pointer moves past the granted requester only on a real issue,
    // so a stalled grant can be overtaken by a lower index next cycle.
    always_comb begin
        rr_d  = rr_q;
        err_d = err_q || (unit_rsp_valid_i && id_empty);
        if (issue) begin
            rr_d = (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + IdWidth'(1);
        end
    end

    // Round-robin pointer and sticky error flag; flush touches neither.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    fpnew_sdotp_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (issue),
        .id_i    (gnt_idx),
        .pop_i   (rsp_pop),
        .full_o  (id_full),
        .empty_o (id_empty),
        .head_o  (head)
    );

endmodule
